// File: rtl/clint_arbiter_if.sv
// Requester-side and CLINT-side signals of the arbiter, bundled as one bus.
// "slave" is the arbiter's view; "master" is the view of the surrounding system.
interface clint_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*ADDR_W-1:0]   req_address;
  logic [N_REQ*DATA_W-1:0]   req_wdata;
  logic [N_REQ*DATA_W/8-1:0] req_wstrb;
  logic [N_REQ-1:0]          req_ready;
  logic [DATA_W-1:0]         req_rdata;
  logic                      req_err;

  logic                      m_valid;
  logic [ADDR_W-1:0]         m_address;
  logic [DATA_W-1:0]         m_wdata;
  logic [DATA_W/8-1:0]       m_wstrb;
  logic [DATA_W-1:0]         m_rdata;
  logic                      m_ready;

  modport slave (
    input  req_valid, req_address, req_wdata, req_wstrb, m_rdata, m_ready,
    output req_ready, req_rdata, req_err, m_valid, m_address, m_wdata, m_wstrb
  );

  modport master (
    output req_valid, req_address, req_wdata, req_wstrb, m_rdata, m_ready,
    input  req_ready, req_rdata, req_err, m_valid, m_address, m_wdata, m_wstrb
  );
endinterface

// File: rtl/clint_arbiter.sv
// Round-robin arbiter funnelling N_REQ requesters onto one CLINT port, one
// transaction at a time, with a bounded wait and a timeout error response.
module clint_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  clint_arbiter_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } lane_req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  lane_req_t [N_REQ-1:0] lane_req;
  lane_req_t             held;
  state_t                state, state_nxt;
  logic [IDX_W-1:0]      grant, last_grant, pick, cand;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_W-1:0]     rsp_data;
  logic                  rsp_err;
  logic                  any_req;
  logic                  timed_out;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane_req[i] = {bus.req_address[i*ADDR_W +: ADDR_W],
                          bus.req_wdata[i*DATA_W +: DATA_W],
                          bus.req_wstrb[i*STRB_W +: STRB_W]};
  end

  // Walk offsets from farthest to nearest so the nearest requester after
  // last_grant is the final (winning) assignment.
  always_comb begin
    any_req = |bus.req_valid;
    pick    = last_grant;
    cand    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(last_grant) + i) % N_REQ);
      if (bus.req_valid[cand]) pick = cand;
    end
  end

  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.m_ready || timed_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // m_ready is only looked at in WAIT; it wins over a same-cycle timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      held       <= '0;
      grant      <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
      cnt        <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          held  <= lane_req[pick];
          grant <= pick;
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (bus.m_ready) begin
            rsp_data <= bus.m_rdata;
            rsp_err  <= 1'b0;
          end else if (timed_out) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: last_grant <= grant;
        default: ;
      endcase
    end
  end

  assign bus.m_valid   = (state == ISSUE);
  assign bus.m_address = held.addr;
  assign bus.m_wdata   = held.wdata;
  assign bus.m_wstrb   = held.wstrb;

  assign bus.req_ready = (state == RESP) ? (N_REQ'(1) << grant) : '0;
  assign bus.req_rdata = (state == RESP) ? rsp_data : '0;
  assign bus.req_err   = (state == RESP) & rsp_err;

endmodule

// File: tb/tb_clint_arbiter.sv
// Scoreboard bench: each posted request queues its expected m_* beat and
// response; a single per-cycle tick models requesters, the CLINT and checks.
module tb_clint_arbiter;
  localparam int N_REQ = 2, ADDR_W = 32, DATA_W = 32, TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  clint_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  clint_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // delay 0 = CLINT never answers; sa/sb = stray m_ready offsets from m_valid (-1 none)
  typedef struct {
    int          lane;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] mdata;
    int          delay;
    int          sa;
    int          sb;
    bit          drop;
  } txn_t;

  txn_t             exp_q[$];
  txn_t             lane_q[N_REQ][$];
  logic [N_REQ-1:0] busy = '0;
  int               cyc = 0, mv_cyc = 0, mv_cnt = 0;
  int               ready_at = -1, stray_a = -1, stray_b = -1;
  logic [31:0]      rsp_data = '0;
  logic             mv_prev = 1'b0;
  int               n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic post(input int lane, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input logic [31:0] mdata, input int delay,
                      input int sa = -1, input int sb = -1, input bit drop = 1'b0);
    txn_t t;
    t = '{lane: lane, addr: addr, wdata: wdata, wstrb: wstrb, mdata: mdata,
          delay: delay, sa: sa, sb: sb, drop: drop};
    exp_q.push_back(t);
    lane_q[lane].push_back(t);
  endtask

  // One clock: sample at the falling edge, check, then drive next inputs.
  task automatic tick();
    txn_t cur;
    @(negedge clk);
    cyc++;
    if (reset) begin
      chk("rst_m",     {bus.m_valid, bus.m_wstrb, bus.m_address}, '0);
      chk("rst_wdata", bus.m_wdata, '0);
      chk("rst_req",   {bus.req_ready, bus.req_err, bus.req_rdata}, '0);
      exp_q.delete();
      for (int l = 0; l < N_REQ; l++) lane_q[l].delete();
      busy          = '0;
      bus.req_valid = '0;
      mv_prev       = 1'b0;
    end else begin
      if (bus.m_valid) begin
        mv_cnt++;
        chk("mv_pulse", mv_prev, 1'b0);
        if (exp_q.size() == 0) chk("mv_unexp", bus.m_valid, 1'b0);
        else begin
          cur = exp_q[0];
          chk("m_addr",  bus.m_address, cur.addr);
          chk("m_wdata", bus.m_wdata,   cur.wdata);
          chk("m_wstrb", bus.m_wstrb,   cur.wstrb);
          mv_cyc   = cyc;
          ready_at = (cur.delay > 0) ? cyc + cur.delay : -1;
          stray_a  = (cur.sa >= 0) ? cyc + cur.sa : -1;
          stray_b  = (cur.sb >= 0) ? cyc + cur.sb : -1;
          rsp_data = cur.mdata;
          if (cur.drop) bus.req_valid[cur.lane] = 1'b0;
        end
      end
      mv_prev = bus.m_valid;

      if (bus.req_ready != '0) begin
        if (exp_q.size() == 0) chk("rdy_unexp", bus.req_ready, '0);
        else begin
          cur = exp_q.pop_front();
          chk("rdy_lane", bus.req_ready, 64'(1) << cur.lane);
          chk("rdata",    bus.req_rdata, (cur.delay > 0) ? cur.mdata : 32'h0);
          chk("err",      bus.req_err,   (cur.delay == 0) ? 1'b1 : 1'b0);
          chk("latency",  cyc - mv_cyc,  (cur.delay > 0) ? cur.delay + 1 : TIMEOUT + 1);
          void'(lane_q[cur.lane].pop_front());
          busy[cur.lane]          = 1'b0;
          bus.req_valid[cur.lane] = 1'b0;
        end
      end else begin
        chk("idle_rsp", {bus.req_err, bus.req_rdata}, '0);
      end

      for (int l = 0; l < N_REQ; l++) begin
        if (!busy[l] && lane_q[l].size() > 0) begin
          cur = lane_q[l][0];
          bus.req_address[l*ADDR_W +: ADDR_W] = cur.addr;
          bus.req_wdata[l*DATA_W +: DATA_W]   = cur.wdata;
          bus.req_wstrb[l*4 +: 4]             = cur.wstrb;
          bus.req_valid[l]                    = 1'b1;
          busy[l]                             = 1'b1;
        end
      end
    end

    // CLINT model keeps running through reset so a stale answer can arrive
    if (cyc == ready_at) begin
      bus.m_ready = 1'b1;
      bus.m_rdata = rsp_data;
    end else if (cyc == stray_a || cyc == stray_b) begin
      bus.m_ready = 1'b1;
      bus.m_rdata = 32'hBAD0_BAD0;
    end else begin
      bus.m_ready = 1'b0;
      bus.m_rdata = $urandom;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    int m0;
    int n;
    bus.req_valid   = '0;
    bus.req_address = '0;
    bus.req_wdata   = '0;
    bus.req_wstrb   = '0;
    bus.m_ready     = 1'b0;
    bus.m_rdata     = '0;
    repeat (3) tick();
    reset = 1'b0;

    // single read, CLINT answers 2 cycles after m_valid
    post(0, 32'h0200_BFF8, 32'h0, 4'h0, 32'h0000_1234, 2);
    drain();

    // write from lane 1
    post(1, 32'h0200_4000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1);
    drain();

    // contention: both lanes busy, grants must alternate 0,1,0,1
    post(0, 32'h0200_0000, 32'h0000_0011, 4'h1, 32'h0000_00A0, 1);
    post(1, 32'h0200_0004, 32'h0000_0022, 4'h3, 32'h0000_00A1, 3);
    post(0, 32'h0200_4008, 32'h0000_0033, 4'hC, 32'h0000_00A2, 2);
    post(1, 32'h0200_400C, 32'h0000_0044, 4'hF, 32'h0000_00A3, 1);
    drain();

    // timeout: CLINT silent
    post(0, 32'h0200_BFFC, 32'h0, 4'h0, 32'h0000_5555, 0);
    drain();

    // stray m_ready in ISSUE and RESP must be ignored
    post(1, 32'h0200_4010, 32'h0, 4'h0, 32'h0000_0077, 3, 0, 4);
    drain();

    // requester drops valid mid-flight; stray m_ready later lands in IDLE
    post(0, 32'h0200_0008, 32'h0000_0001, 4'h1, 32'h0000_0088, 2, -1, 5, 1'b1);
    drain();
    repeat (6) tick();

    post(1, 32'h0200_4014, 32'h0, 4'h0, 32'h0000_00B1, 2);
    drain();
    post(0, 32'h0200_0010, 32'h0, 4'h0, 32'h0000_00B2, 1);
    drain();

    // reset mid-WAIT: last grant was lane 0, yet lane 0 must win afterwards
    m0 = mv_cnt;
    post(1, 32'h0200_4018, 32'h0, 4'h0, 32'h0000_0099, 5);
    n = 0;
    while (mv_cnt == m0 && n < 50) begin
      tick();
      n++;
    end
    chk("mv_wait", mv_cnt - m0, 1);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("abort_q", exp_q.size(), 0);
    post(0, 32'h0200_0020, 32'h0000_0055, 4'h5, 32'h0000_00C0, 1);
    post(1, 32'h0200_4020, 32'h0000_0066, 4'h6, 32'h0000_00C1, 2);
    drain();
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
